sseg_scan_capture: RTL and testbench

- Receive-side counterpart of the seven-segment decoder path.
- Samples a multiplexed seven-segment display bus (anode select plus cathode pattern) and recovers the hex digits being shown.
- Debounces each digit dwell, maps segment patterns back to nibbles, assembles a full frame, and reports it with a one-cycle valid pulse.
- Used as a self-check monitor on board and as a scoreboard front-end in benches.

---
 rtl/sseg_scan_capture.sv | 212 +++++++++++++++++++++
 tb/tb_sseg_scan_capture.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_capture.sv
// sseg_scan_capture: recovers hex digits from a multiplexed seven-segment bus.
// Ports: clk, reset (sync, active-high), anode (active-low digit select),
//   cathode (active-high a..g, dp), value (last frame, 4 bits per slot),
//   frame_valid (1-cycle pulse), frame_err (with frame_valid), stale (level),
//   dp_out (decimal points of last frame).
// Optional macro SSEG_SCAN_CAPTURE_DP_EN: capture cathode[7] as dp bits;
//   when undefined dp_out is 0 and cathode[7] is ignored.
module sseg_scan_capture #(
   parameter int DIGITS         = 4,
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DIGITS-1:0]   anode,
   input  logic [7:0]          cathode,
   output logic [4*DIGITS-1:0] value,
   output logic                frame_valid,
   output logic                frame_err,
   output logic                stale,
   output logic [DIGITS-1:0]   dp_out
);

   localparam int CW = $clog2(SETTLE_CYCLES);
   localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int SW = $clog2(DIGITS);
   localparam logic [CW-1:0] CNT_MAX   = CW'(SETTLE_CYCLES - 1);
   localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT_CYCLES);
   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

`ifdef SSEG_SCAN_CAPTURE_DP_EN
   localparam logic [7:0] KEY_MASK = 8'hFF;
`else
   localparam logic [7:0] KEY_MASK = 8'h7F;
`endif

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

   state_t              state_q, state_d;
   logic [DIGITS+7:0]   key, prev_q;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idle_q, idle_d;
   logic [DIGITS-1:0]   seen_q, seen_d;
   logic [4*DIGITS-1:0] nib_q, nib_d, value_q, value_d;
   logic                bad_q, bad_d;
   logic                fv_q, fv_d;
   logic                err_q, err_d;
   logic                stale_q, stale_d;
   logic                same, active, illegal, sample, full, tmo;
   logic [SW-1:0]       slot;
   logic [4:0]          dec;

   // {valid, nibble}; unknown patterns decode to nibble 0
   function automatic logic [4:0] seg_decode(input logic [6:0] s);
      case (s)
         7'h3F:   seg_decode = 5'h10;
         7'h06:   seg_decode = 5'h11;
         7'h5B:   seg_decode = 5'h12;
         7'h4F:   seg_decode = 5'h13;
         7'h66:   seg_decode = 5'h14;
         7'h6D:   seg_decode = 5'h15;
         7'h7D:   seg_decode = 5'h16;
         7'h07:   seg_decode = 5'h17;
         7'h7F:   seg_decode = 5'h18;
         7'h6F:   seg_decode = 5'h19;
         7'h77:   seg_decode = 5'h1A;
         7'h7C:   seg_decode = 5'h1B;
         7'h39:   seg_decode = 5'h1C;
         7'h5E:   seg_decode = 5'h1D;
         7'h79:   seg_decode = 5'h1E;
         7'h71:   seg_decode = 5'h1F;
         default: seg_decode = 5'h00;
      endcase
   endfunction

   // anode classification and active slot index
   always_comb begin
      active  = ($countones(~anode) == 1);
      illegal = ($countones(~anode) > 1);
      slot    = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!anode[i]) slot = SW'(i);
      end
   end

   // dwell counter and sampling FSM
   always_comb begin
      key     = {anode, cathode & KEY_MASK};
      same    = (key == prev_q);
      cnt_d   = '0;
      sample  = 1'b0;
      state_d = state_q;
      if (same) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end
      if (!active) begin
         state_d = IDLE;
      end else if (!same) begin
         state_d = SETTLE;
      end else begin
         unique case (state_q)
            IDLE:    state_d = SETTLE;
            SETTLE: begin
               if (cnt_d == CNT_MAX) begin
                  sample  = 1'b1;
                  state_d = HOLD;
               end
            end
            HOLD:    state_d = HOLD;
            default: state_d = IDLE;
         endcase
      end
   end

   // frame assembly, completion and stale tracking
   always_comb begin
      dec     = seg_decode(cathode[6:0]);
      full    = &seen_q;
      tmo     = !sample && (idle_q == IDLE_LAST);
      seen_d  = seen_q;
      bad_d   = bad_q;
      nib_d   = nib_q;
      value_d = value_q;
      fv_d    = 1'b0;
      err_d   = 1'b0;
      stale_d = stale_q;
      idle_d  = '0;
      if (!sample) begin
         idle_d = (idle_q == IDLE_MAX) ? idle_q : idle_q + 1'b1;
      end
      // completion reports the pre-sample frame; a same-cycle
      // sample below lands in the freshly cleared next frame
      if (full) begin
         value_d = nib_q;
         fv_d    = 1'b1;
         err_d   = bad_q;
         seen_d  = '0;
         bad_d   = 1'b0;
      end
      if (tmo) begin
         stale_d = 1'b1;
         seen_d  = '0;
         bad_d   = 1'b0;
      end
      // flag an illegal select once, on the first cycle of its dwell
      if (illegal && !same) bad_d = 1'b1;
      if (sample) begin
         stale_d                  = 1'b0;
         seen_d[slot]             = 1'b1;
         nib_d[int'(slot)*4 +: 4] = dec[3:0];
         if (!dec[4]) bad_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         prev_q  <= '0;
         cnt_q   <= '0;
         idle_q  <= '0;
         seen_q  <= '0;
         bad_q   <= 1'b0;
         nib_q   <= '0;
         value_q <= '0;
         fv_q    <= 1'b0;
         err_q   <= 1'b0;
         stale_q <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= key;
         cnt_q   <= cnt_d;
         idle_q  <= idle_d;
         seen_q  <= seen_d;
         bad_q   <= bad_d;
         nib_q   <= nib_d;
         value_q <= value_d;
         fv_q    <= fv_d;
         err_q   <= err_d;
         stale_q <= stale_d;
      end
   end

`ifdef SSEG_SCAN_CAPTURE_DP_EN
   logic [DIGITS-1:0] dps_q, dps_d, dp_q, dp_d;

   always_comb begin
      dps_d = dps_q;
      dp_d  = full ? dps_q : dp_q;
      if (sample) dps_d[slot] = cathode[7];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dps_q <= '0;
         dp_q  <= '0;
      end else begin
         dps_q <= dps_d;
         dp_q  <= dp_d;
      end
   end

   assign dp_out = dp_q;
`else
   assign dp_out = '0;
`endif

   assign value       = value_q;
   assign frame_valid = fv_q;
   assign frame_err   = err_q;
   assign stale       = stale_q;

endmodule

// File: tb/tb_sseg_scan_capture.sv
// tb_sseg_scan_capture: directed table plus randomized dwells for
//   sseg_scan_capture, checked every cycle against a behavioural model.
module tb_sseg_scan_capture;

   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 1024;

`ifdef SSEG_SCAN_CAPTURE_DP_EN
   localparam logic [7:0] KEY_MASK = 8'hFF;
   localparam logic [3:0] DP_EXP   = 4'b0010;
`else
   localparam logic [7:0] KEY_MASK = 8'h7F;
   localparam logic [3:0] DP_EXP   = 4'b0000;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  anode = 4'hF;
   logic [7:0]  cathode = 8'h00;
   logic [15:0] value;
   logic        frame_valid;
   logic        frame_err;
   logic        stale;
   logic [3:0]  dp_out;

   sseg_scan_capture #(
      .DIGITS(4),
      .SETTLE_CYCLES(SETTLE),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .anode(anode),
      .cathode(cathode),
      .value(value),
      .frame_valid(frame_valid),
      .frame_err(frame_err),
      .stale(stale),
      .dp_out(dp_out)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_miss = 0;
   int cyc = 0;
   int fv_obs = 0;
   int err_obs = 0;

   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
      7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // behavioural model state
   int          run;
   bit          have_prev;
   logic [11:0] prev_key;
   logic [3:0]  m_seen, m_dps;
   logic [15:0] m_nib;
   bit          m_bad;
   int          m_idle;
   logic [15:0] e_val;
   logic        e_fv, e_err, e_stale;
   logic [3:0]  e_dp;

   function automatic int seg_lookup(input logic [6:0] p);
      for (int i = 0; i < 16; i++) if (seg_tab[i] == p) return i;
      return -1;
   endfunction

   task automatic model(input logic [3:0] an, input logic [7:0] ca,
                        input logic rst);
      logic [11:0] k;
      int ones, sl, d;
      bit act, ill, smp;
      if (rst) begin
         m_seen = 0; m_dps = 0; m_nib = 0; m_bad = 0; m_idle = 0;
         have_prev = 0; run = 0;
         e_val = 0; e_fv = 0; e_err = 0; e_stale = 0; e_dp = 0;
      end else begin
         k = {an, ca & KEY_MASK};
         if (have_prev && k == prev_key) begin
            if (run < 1000) run++;
         end else begin
            run = 1;
         end
         prev_key = k;
         have_prev = 1;
         ones = $countones(~an);
         act = (ones == 1);
         ill = (ones > 1);
         sl = 0;
         for (int i = 0; i < 4; i++) if (!an[i]) sl = i;
         smp = act && (run == SETTLE);
         e_fv = 0;
         e_err = 0;
         if (m_seen == 4'hF) begin
            e_fv = 1; e_val = m_nib; e_err = m_bad; e_dp = m_dps;
            m_seen = 0; m_bad = 0;
         end
         if (smp) begin
            m_idle = 0;
            e_stale = 0;
         end else if (m_idle < 1000000) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
               e_stale = 1; m_seen = 0; m_bad = 0;
            end
         end
         if (ill && run == 1) m_bad = 1;
         if (smp) begin
            d = seg_lookup(ca[6:0]);
            m_nib[sl*4 +: 4] = (d < 0) ? 4'h0 : d[3:0];
            if (d < 0) m_bad = 1;
            m_seen[sl] = 1'b1;
`ifdef SSEG_SCAN_CAPTURE_DP_EN
            m_dps[sl] = ca[7];
`endif
         end
      end
   endtask

   task automatic step(input logic [3:0] an, input logic [7:0] ca,
                       input logic rst);
      anode = an;
      cathode = ca;
      reset = rst;
      @(posedge clk);
      model(an, ca, rst);
      #1;
      cyc++;
      n_vec++;
      if (frame_valid === 1'b1) fv_obs++;
      if (frame_err === 1'b1) err_obs++;
      if ({value, frame_valid, frame_err, stale, dp_out} !==
          {e_val, e_fv, e_err, e_stale, e_dp}) begin
         n_miss++;
         $display("FAIL cyc%0d outputs got val=%h fv=%b err=%b stale=%b dp=%b want val=%h fv=%b err=%b stale=%b dp=%b",
                  cyc, value, frame_valid, frame_err, stale, dp_out,
                  e_val, e_fv, e_err, e_stale, e_dp);
      end
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0]  an;
      logic [7:0]  ca;
      int          len;
      logic [15:0] val;
      int          fv;
      int          err;
      logic [3:0]  dp;
   } vec_t;

   vec_t tab[$];

   function automatic void add(input logic [3:0] an, input logic [7:0] ca,
                               input int len, input logic [15:0] val,
                               input int fv, input int err,
                               input logic [3:0] dp);
      vec_t v;
      v.an = an; v.ca = ca; v.len = len; v.val = val;
      v.fv = fv; v.err = err; v.dp = dp;
      tab.push_back(v);
   endfunction

   initial begin
      logic [3:0] an;
      logic [7:0] ca;
      int f0, e0, r, len;

      // normal frame
      add(4'b1110, 8'h06, 8, 16'h0000, 0, 0, 4'h0);
      add(4'b1101, 8'h5B, 8, 16'h0000, 0, 0, 4'h0);
      add(4'b1011, 8'h4F, 8, 16'h0000, 0, 0, 4'h0);
      add(4'b0111, 8'h66, 8, 16'h4321, 1, 0, 4'h0);
      // glitch rejection: 3-cycle dwell never sampled
      add(4'b1110, 8'h06, 3, 16'h4321, 0, 0, 4'h0);
      add(4'b1110, 8'h4F, 8, 16'h4321, 0, 0, 4'h0);
      add(4'b1101, 8'h71, 8, 16'h4321, 0, 0, 4'h0);
      add(4'b1011, 8'h79, 8, 16'h4321, 0, 0, 4'h0);
      add(4'b0111, 8'h5E, 8, 16'hDEF3, 1, 0, 4'h0);
      // invalid pattern in slot 2
      add(4'b1110, 8'h3F, 8, 16'hDEF3, 0, 0, 4'h0);
      add(4'b1101, 8'h06, 8, 16'hDEF3, 0, 0, 4'h0);
      add(4'b1011, 8'h00, 8, 16'hDEF3, 0, 0, 4'h0);
      add(4'b0111, 8'h5B, 8, 16'h2010, 1, 1, 4'h0);
      // illegal anode then a valid frame
      add(4'b1100, 8'h06, 6, 16'h2010, 0, 0, 4'h0);
      add(4'b1110, 8'h06, 8, 16'h2010, 0, 0, 4'h0);
      add(4'b1101, 8'h06, 8, 16'h2010, 0, 0, 4'h0);
      add(4'b1011, 8'h06, 8, 16'h2010, 0, 0, 4'h0);
      add(4'b0111, 8'h06, 8, 16'h1111, 1, 1, 4'h0);
      // exact SETTLE-length dwells; pulse lands in the next dwell
      add(4'b1110, 8'h7D, 4, 16'h1111, 0, 0, 4'h0);
      add(4'b1101, 8'h07, 4, 16'h1111, 0, 0, 4'h0);
      add(4'b1011, 8'h7F, 4, 16'h1111, 0, 0, 4'h0);
      add(4'b0111, 8'h6F, 4, 16'h1111, 0, 0, 4'h0);
      add(4'b1111, 8'h00, 2, 16'h9876, 1, 0, 4'h0);
      // decimal point on slot 1
      add(4'b1110, 8'h3F, 8, 16'h9876, 0, 0, 4'h0);
      add(4'b1101, 8'h86, 8, 16'h9876, 0, 0, 4'h0);
      add(4'b1011, 8'h5B, 8, 16'h9876, 0, 0, 4'h0);
      add(4'b0111, 8'h4F, 8, 16'h3210, 1, 0, DP_EXP);

      // reset held with an active digit present
      repeat (3) step(4'b1110, 8'h06, 1'b1);
      check("reset_out", {value, frame_valid, frame_err, stale, dp_out},
            32'h0);

      for (int i = 0; i < tab.size(); i++) begin
         f0 = fv_obs;
         e0 = err_obs;
         repeat (tab[i].len) step(tab[i].an, tab[i].ca, 1'b0);
         check($sformatf("tab%0d_val", i), 32'(value), 32'(tab[i].val));
         check($sformatf("tab%0d_fv", i), fv_obs - f0, tab[i].fv);
         check($sformatf("tab%0d_err", i), err_obs - e0, tab[i].err);
         check($sformatf("tab%0d_dp", i), 32'(dp_out), 32'(tab[i].dp));
      end

      // timeout: 4 idle cycles already elapsed after the last sample
      repeat (1000) step(4'b1111, 8'h00, 1'b0);
      check("stale_early", 32'(stale), 32'h0);
      repeat (30) step(4'b1111, 8'h00, 1'b0);
      check("stale_set", 32'(stale), 32'h1);
      check("stale_val", 32'(value), 32'h3210);
      repeat (4) step(4'b1110, 8'h06, 1'b0);
      check("stale_clr", 32'(stale), 32'h0);

      // mid-frame reset discards the partial frame
      repeat (8) step(4'b1101, 8'h5B, 1'b0);
      f0 = fv_obs;
      step(4'b1111, 8'h00, 1'b1);
      check("rst_val", 32'(value), 32'h0);
      repeat (8) step(4'b1011, 8'h06, 1'b0);
      repeat (8) step(4'b0111, 8'h06, 1'b0);
      repeat (4) step(4'b1111, 8'h00, 1'b0);
      check("rst_nofv", fv_obs - f0, 0);

      // randomized dwells
      for (int d = 0; d < 700; d++) begin
         r = $urandom_range(0, 99);
         if (r < 75) begin
            an = ~(4'b0001 << $urandom_range(0, 3));
         end else if (r < 88) begin
            an = 4'hF;
         end else begin
            do an = 4'($urandom); while ($countones(~an) < 2);
         end
         if ($urandom_range(0, 9) == 0) ca = 8'($urandom);
         else ca = {1'($urandom_range(0, 1)), seg_tab[$urandom_range(0, 15)]};
         len = $urandom_range(1, 7);
         repeat (len) step(an, ca, 1'b0);
         if ($urandom_range(0, 9) == 0) begin
            repeat (2) step(an, ca ^ 8'h80, 1'b0);
         end
         if ($urandom_range(0, 199) == 0) step(4'hF, 8'h00, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
